cog_clkgen: RTL and testbench

COG_CLKGEN -- requirements
Module: cog_clkgen

---
 rtl/clkgen_pkg.sv | 37 +++
 rtl/cog_clkgen_if.sv | 17 +
 rtl/clkgen_chan.sv | 89 ++++++++
 rtl/cog_clkgen.sv | 58 +++++
 tb/tb_cog_clkgen.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/clkgen_pkg.sv
// Clock-select encodings and divider increment decode shared by the cog clock generator.
package clkgen_pkg;

  localparam int CFG_W = 7;
  localparam int SEL_W = 5;

  typedef enum logic [SEL_W-1:0] {
    CS_PLL16X = 5'b11111,
    CS_PLL8X  = 5'b11110,
    CS_PLL4X  = 5'b11101,
    CS_PLL2X  = 5'b11100,
    CS_PLL1X  = 5'b11011,
    CS_XINPUT = 5'b01010
  } clksel_e;

  // RC oscillator modes only look at the low three select bits.
  localparam logic [2:0] RCFAST_LO = 3'b000;
  localparam logic [2:0] RCSLOW_LO = 3'b001;

  // Per-cycle divider increment for a clksel; div_w is at most 32.
  function automatic logic [31:0] inc_decode(input logic [SEL_W-1:0] sel, input int div_w);
    inc_decode = '0;
    case (sel)
      CS_PLL16X:           inc_decode = 32'd1 << (div_w - 1);
      CS_PLL8X:            inc_decode = 32'd1 << (div_w - 2);
      CS_PLL4X:            inc_decode = 32'd1 << (div_w - 3);
      CS_PLL2X:            inc_decode = 32'd1 << (div_w - 4);
      CS_PLL1X, CS_XINPUT: inc_decode = 32'd1 << (div_w - 5);
      default: begin
        if (sel[2:0] == RCFAST_LO)      inc_decode = 32'd1 << (div_w - 4);
        else if (sel[2:0] == RCSLOW_LO) inc_decode = 32'd1;
        else                            inc_decode = '0;
      end
    endcase
  endfunction

endpackage

// File: rtl/cog_clkgen_if.sv
// Config write handshake into the cog clock generator.
interface cog_clkgen_if #(
  parameter int CHANNELS = 2
);
  import clkgen_pkg::*;

  localparam int CHAN_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic              cfg_valid;
  logic              cfg_ready;
  logic [CHAN_W-1:0] cfg_chan;
  logic [CFG_W-1:0]  cfg_data;

  modport master (output cfg_valid, output cfg_chan, output cfg_data, input cfg_ready);
  modport slave  (input cfg_valid, input cfg_chan, input cfg_data, output cfg_ready);

endinterface

// File: rtl/clkgen_chan.sv
// One cog clock channel: phase accumulator divider with a shadowed clock select
// that only switches at a clk_cog fall, while stopped, or under chan_res.
//
// state   | meaning
// ST_IDLE | running on the active select, ready for a write
// ST_PEND | shadow select waiting for a safe switch point (busy)
module clkgen_chan
  import clkgen_pkg::*;
#(
  parameter int               DIV_W     = 13,
  parameter logic [SEL_W-1:0] RESET_SEL = '0
) (
  input  logic             clock,
  input  logic             res_n,
  input  logic             chan_res,
  input  logic             wr,
  input  logic [SEL_W-1:0] wr_sel,
  output logic             busy,
  output logic             clk_cog,
  output logic             cog_en,
  output logic             pll_en
);

  typedef enum logic {ST_IDLE, ST_PEND} state_e;

  localparam logic [DIV_W-1:0] HALF = {1'b1, {(DIV_W-1){1'b0}}};

  state_e           state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d, shadow_q, shadow_d;
  logic [DIV_W-1:0] div_q, div_d, inc, sum;
  logic             cog_en_q, cog_en_d, pll_en_q, pll_en_d;
  logic             wrap, apply, half;

  always_ff @(posedge clock or negedge res_n) begin
    if (!res_n) begin
      state_q  <= ST_IDLE;
      sel_q    <= RESET_SEL;
      shadow_q <= '0;
      div_q    <= '0;
      cog_en_q <= 1'b0;
      pll_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      shadow_q <= shadow_d;
      div_q    <= div_d;
      cog_en_q <= cog_en_d;
      pll_en_q <= pll_en_d;
    end
  end

  always_comb begin
    inc      = chan_res ? HALF : DIV_W'(inc_decode(sel_q, DIV_W));
    sum      = div_q + inc;
    wrap     = div_q[DIV_W-1] & ~sum[DIV_W-1];
    half     = (inc == HALF);
    state_d  = state_q;
    sel_d    = sel_q;
    shadow_d = shadow_q;
    div_d    = sum;
    apply    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (wr) begin
          shadow_d = wr_sel;
          state_d  = ST_PEND;
        end
      end
      ST_PEND: begin
        if (wrap || inc == '0 || chan_res) begin
          apply   = 1'b1;
          sel_d   = shadow_q;
          div_d   = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // The switch cycle restarts the divider, so it never counts as a step.
    cog_en_d = div_d[DIV_W-1] & ~div_q[DIV_W-1];
    pll_en_d = (div_d[DIV_W-2] & ~div_q[DIV_W-2]) | (half & ~apply);
  end

  assign busy    = (state_q == ST_PEND);
  assign clk_cog = div_q[DIV_W-1];
  assign cog_en  = cog_en_q;
  assign pll_en  = pll_en_q;

endmodule

// File: rtl/cog_clkgen.sv
// Cog clock generator: CHANNELS independent dividers off the fast PLL clock,
// reconfigured through a single valid/ready write port.
module cog_clkgen
  import clkgen_pkg::*;
#(
  parameter int               CHANNELS  = 2,
  parameter int               DIV_W     = 13,
  parameter logic [CFG_W-1:0] RESET_CFG = 7'h00
) (
  input  logic                clock,
  input  logic                res_n,
  cog_clkgen_if.slave         cfg,
  input  logic [CHANNELS-1:0] chan_res,
  output logic [CHANNELS-1:0] busy,
  output logic [CHANNELS-1:0] clk_cog,
  output logic [CHANNELS-1:0] cog_en,
  output logic [CHANNELS-1:0] pll_en
);

  localparam int CHAN_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic [CHANNELS-1:0] sel_hit;
  logic [SEL_W-1:0]    wr_sel;
  logic                ready;
  logic                unused_oscm;

  // Out-of-range channel numbers match nothing and so read as not ready.
  always_comb begin
    sel_hit = '0;
    ready   = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      sel_hit[i] = (cfg.cfg_chan == CHAN_W'(i));
      if (sel_hit[i]) ready = ~busy[i];
    end
  end

  assign wr_sel        = {cfg.cfg_data[6:5], cfg.cfg_data[2:0]};
  assign unused_oscm   = ^cfg.cfg_data[4:3];
  assign cfg.cfg_ready = ready;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    clkgen_chan #(
      .DIV_W     (DIV_W),
      .RESET_SEL ({RESET_CFG[6:5], RESET_CFG[2:0]})
    ) u_chan (
      .clock    (clock),
      .res_n    (res_n),
      .chan_res (chan_res[i]),
      .wr       (cfg.cfg_valid & ready & sel_hit[i]),
      .wr_sel   (wr_sel),
      .busy     (busy[i]),
      .clk_cog  (clk_cog[i]),
      .cog_en   (cog_en[i]),
      .pll_en   (pll_en[i])
    );
  end

endmodule

// File: tb/tb_cog_clkgen.sv
// Bench for cog_clkgen: directed scenarios plus random traffic against a
// phase-accumulator reference model on an 8192-step cycle.
module tb_cog_clkgen;

  localparam int CH = 2;
  localparam int DW = 13;

  logic          clock = 1'b0;
  logic          res_n = 1'b0;
  logic [CH-1:0] chan_res = '0;
  logic [CH-1:0] busy, clk_cog, cog_en, pll_en;

  cog_clkgen_if #(.CHANNELS(CH)) ifc ();

  cog_clkgen #(.CHANNELS(CH), .DIV_W(DW), .RESET_CFG(7'h00)) dut (
    .clock    (clock),
    .res_n    (res_n),
    .cfg      (ifc),
    .chan_res (chan_res),
    .busy     (busy),
    .clk_cog  (clk_cog),
    .cog_en   (cog_en),
    .pll_en   (pll_en)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  int unsigned m_div [CH];
  logic [6:0]  m_cfg [CH];
  logic [6:0]  m_shd [CH];
  bit          m_pend[CH];
  bit          m_cog [CH];
  bit          m_pll [CH];
  bit          m_acc;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Steps per cycle out of 8192; a full cog period is 8192/rate cycles.
  function automatic int unsigned rate(input logic [6:0] c);
    logic [4:0] s;
    s = {c[6:5], c[2:0]};
    case (s)
      5'b11111: return 4096;
      5'b11110: return 2048;
      5'b11101: return 1024;
      5'b11100: return 512;
      5'b11011, 5'b01010: return 256;
      default: ;
    endcase
    if (s[2:0] == 3'b000) return 512;
    if (s[2:0] == 3'b001) return 1;
    return 0;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      m_div[c] = 0; m_cfg[c] = 7'h00; m_shd[c] = 7'h00;
      m_pend[c] = 0; m_cog[c] = 0; m_pll[c] = 0;
    end
  endtask

  task automatic model_step();
    int unsigned inc, nxt, nd;
    bit stepped;
    m_acc = ifc.cfg_valid && !m_pend[ifc.cfg_chan];
    for (int c = 0; c < CH; c++) begin
      inc = chan_res[c] ? 4096 : rate(m_cfg[c]);
      nxt = (m_div[c] + inc) % 8192;
      nd = nxt;
      stepped = 1;
      if (m_pend[c] && ((m_div[c] >= 4096 && nxt < 4096) || inc == 0 || chan_res[c])) begin
        m_cfg[c] = m_shd[c]; m_pend[c] = 0; nd = 0; stepped = 0;
      end
      m_cog[c] = (nd >= 4096) && (m_div[c] < 4096);
      m_pll[c] = (((nd / 2048) % 2 == 1) && ((m_div[c] / 2048) % 2 == 0)) || (stepped && inc == 4096);
      m_div[c] = nd;
    end
    if (m_acc) begin
      m_shd[ifc.cfg_chan] = ifc.cfg_data;
      m_pend[ifc.cfg_chan] = 1;
    end
  endtask

  // Called just after a rising edge with inputs already set for this cycle.
  task automatic tick();
    #1;
    check("cfg_ready", int'(ifc.cfg_ready), int'(!m_pend[ifc.cfg_chan]));
    model_step();
    @(posedge clock); #1;
    cyc++;
    for (int c = 0; c < CH; c++) begin
      check($sformatf("clk_cog%0d", c), int'(clk_cog[c]), int'(m_div[c] >= 4096));
      check($sformatf("cog_en%0d", c),  int'(cog_en[c]),  int'(m_cog[c]));
      check($sformatf("pll_en%0d", c),  int'(pll_en[c]),  int'(m_pll[c]));
      check($sformatf("busy%0d", c),    int'(busy[c]),    int'(m_pend[c]));
    end
  endtask

  task automatic cfg_write(input int ch, input logic [6:0] d);
    int n;
    n = 0;
    ifc.cfg_valid = 1'b1; ifc.cfg_chan = 1'(ch); ifc.cfg_data = d;
    do begin
      tick();
      n++;
    end while (!m_acc && n < 10000);
    ifc.cfg_valid = 1'b0;
    check("wr_accept", int'(m_acc), 1);
  endtask

  task automatic measure(input int ch, input int n, output int gap, output int n_cog, output int n_pll);
    int last;
    last = -1; gap = -1; n_cog = 0; n_pll = 0;
    repeat (n) begin
      tick();
      if (cog_en[ch]) begin
        if (last >= 0) gap = cyc - last;
        last = cyc;
        n_cog++;
      end
      if (pll_en[ch]) n_pll++;
    end
  endtask

  task automatic check_all_low(input string tag);
    check({tag, "_clk_cog"}, int'(clk_cog), 0);
    check({tag, "_cog_en"},  int'(cog_en),  0);
    check({tag, "_pll_en"},  int'(pll_en),  0);
    check({tag, "_busy"},    int'(busy),    0);
  endtask

  initial begin
    int gap, ncog, npll, n;
    logic [6:0] pick [12];
    pick = '{7'h00, 7'h18, 7'h67, 7'h7F, 7'h66, 7'h65, 7'h64, 7'h63, 7'h22, 7'h02, 7'h01, 7'h4B};
    model_reset();
    ifc.cfg_valid = 1'b0; ifc.cfg_chan = '0; ifc.cfg_data = '0;

    #12;
    check_all_low("rst");
    check("rst_ready", int'(ifc.cfg_ready), 1);
    @(posedge clock); #1;
    res_n = 1'b1;

    measure(0, 40, gap, ncog, npll);
    check("rcfast_gap", gap, 16);
    check("rcfast_ncog", ncog, 3);
    check("rcfast_npll", npll, 5);

    cfg_write(0, 7'h67);
    repeat (20) tick();
    measure(0, 20, gap, ncog, npll);
    check("pll16_gap", gap, 2);
    check("pll16_ncog", ncog, 10);
    check("pll16_npll", npll, 20);
    measure(1, 32, gap, ncog, npll);
    check("ch1_untouched_gap", gap, 16);

    n = 0;
    while (m_div[1] != 1024 && n < 64) begin tick(); n++; end
    check("wait_div400", int'(m_div[1] == 1024), 1);
    cfg_write(1, 7'h66);
    ifc.cfg_chan = 1'b1;
    #1;
    check("ch1_ready_low", int'(ifc.cfg_ready), 0);
    repeat (16) tick();
    measure(1, 20, gap, ncog, npll);
    check("pll8_gap", gap, 4);
    check("pll8_ncog", ncog, 5);
    ifc.cfg_chan = 1'b0;

    cfg_write(0, 7'h02);
    repeat (4) tick();
    measure(0, 20, gap, ncog, npll);
    check("stop_ncog", ncog, 0);
    check("stop_npll", npll, 0);
    cfg_write(0, 7'h22);
    tick();
    check("xin_apply_next", int'(busy[0]), 0);
    measure(0, 70, gap, ncog, npll);
    check("xin_gap", gap, 32);

    chan_res[0] = 1'b1;
    cfg_write(0, 7'h00);
    tick();
    check("res_apply_next", int'(busy[0]), 0);
    measure(0, 10, gap, ncog, npll);
    check("res_gap", gap, 2);
    check("res_ncog", ncog, 5);
    chan_res[0] = 1'b0;

    cfg_write(1, 7'h63);
    check("busy_pre_rst", int'(busy[1]), 1);
    res_n = 1'b0;
    #1;
    check_all_low("async_rst");
    model_reset();
    @(posedge clock); #1;
    check_all_low("held_rst");
    res_n = 1'b1;
    measure(0, 32, gap, ncog, npll);
    check("post_rst_gap0", gap, 16);
    measure(1, 32, gap, ncog, npll);
    check("post_rst_gap1", gap, 16);

    repeat (3000) begin
      for (int c = 0; c < CH; c++)
        if ($urandom_range(63) == 0) chan_res[c] = ~chan_res[c];
      ifc.cfg_valid = ($urandom_range(3) == 0);
      ifc.cfg_chan  = 1'($urandom_range(1));
      ifc.cfg_data  = ($urandom_range(7) == 0) ? 7'($urandom) : pick[$urandom_range(11)];
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
